// File: rtl/timer_pkg.sv
// Shared definitions for the memory-mapped countdown timer: FSM states,
// register offsets, CTRL bit positions and MODE encodings.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CNT  = 2'd2,
        INT  = 2'd3
    } state_t;

    // Word offsets within the register window (addr[3:2])
    localparam logic [1:0] OFF_CTRL   = 2'd0;
    localparam logic [1:0] OFF_PRESET = 2'd1;
    localparam logic [1:0] OFF_COUNT  = 2'd2;

    // CTRL bit positions
    localparam int CTRL_EN      = 0;
    localparam int CTRL_MODE_LO = 1;
    localparam int CTRL_MODE_HI = 2;
    localparam int CTRL_IM      = 3;

    // MODE encodings; 2 and 3 fall back to one-shot behaviour
    localparam logic [1:0] MODE_ONESHOT = 2'd0;
    localparam logic [1:0] MODE_RELOAD  = 2'd1;

endpackage

// File: rtl/byte_merge.sv
// Byte-lane merge: lanes with i_mask[i]=1 take i_new, the rest keep i_old.
module byte_merge (
    input  logic [31:0] i_old,
    input  logic [31:0] i_new,
    input  logic [3:0]  i_mask,
    output logic [31:0] o_merged
);

    // Per-lane select between the old word and the incoming write data
    always_comb begin
        o_merged = i_old;
        for (int i = 0; i < 4; i++) begin
            if (i_mask[i]) begin
                o_merged[8*i +: 8] = i_new[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/timer_device.sv
// Memory-mapped countdown timer with one-shot and auto-reload modes.
// Snoops the CPU data bus, exposes CTRL/PRESET/COUNT and drives an IRQ.
module timer_device
    import timer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [3:0]  byteen,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        hit,
    output logic        irq
);

    state_t      r_state;
    logic [3:0]  r_ctrl;
    logic [31:0] r_preset;
    logic [31:0] r_count;
    logic        r_irq_flag;

    state_t      w_state_nxt;
    logic [31:0] w_count_nxt;
    logic        w_flag_nxt;
    logic        w_en_clr;

    logic        w_hit;
    logic [1:0]  w_off;
    logic        w_wr;
    logic        w_wr_ctrl;
    logic        w_wr_preset;
    logic        w_en;
    logic        w_reload;
    logic [31:0] w_ctrl_fsm;
    logic [31:0] w_ctrl_merged;
    logic [31:0] w_preset_merged;
    logic        w_unused;

    assign w_off       = addr[3:2];
    assign w_hit       = (addr[31:4] == BASE_ADDR[31:4]) && (w_off != 2'b11);
    assign w_wr        = w_hit && (|byteen);
    assign w_wr_ctrl   = w_wr && (w_off == OFF_CTRL);
    assign w_wr_preset = w_wr && (w_off == OFF_PRESET);
    assign w_en        = r_ctrl[CTRL_EN];
    assign w_reload    = (r_ctrl[CTRL_MODE_HI:CTRL_MODE_LO] == MODE_RELOAD);

    // The FSM-updated CTRL is the "old" word for the merge, so written lanes
    // override the one-shot EN clear while unwritten lanes keep the FSM result.
    assign w_ctrl_fsm = {28'd0, r_ctrl[3:1], r_ctrl[CTRL_EN] & ~w_en_clr};

    byte_merge u_ctrl_merge (
        .i_old    (w_ctrl_fsm),
        .i_new    (wdata),
        .i_mask   (byteen),
        .o_merged (w_ctrl_merged)
    );

    byte_merge u_preset_merge (
        .i_old    (r_preset),
        .i_new    (wdata),
        .i_mask   (byteen),
        .o_merged (w_preset_merged)
    );

    // Byte offset bits and the unimplemented CTRL bits are intentionally dropped
    assign w_unused = ^{addr[1:0], w_ctrl_merged[31:4]};

    // Next-state and datapath decisions from pre-edge register values
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_flag_nxt  = r_irq_flag;
        w_en_clr    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_en) begin
                    w_state_nxt = LOAD;
                end
            end
            LOAD: begin
                w_count_nxt = r_preset;
                w_state_nxt = CNT;
            end
            CNT: begin
                if (!w_en) begin
                    w_state_nxt = IDLE;
                end else if (r_count > 32'd1) begin
                    w_count_nxt = r_count - 32'd1;
                end else begin
                    // COUNT of 1 or 0 both expire here, so it never wraps
                    w_count_nxt = 32'd0;
                    w_flag_nxt  = 1'b1;
                    w_state_nxt = INT;
                end
            end
            INT: begin
                w_state_nxt = IDLE;
                if (w_reload) begin
                    // EN stays set, so IDLE immediately re-enters LOAD
                    w_flag_nxt = 1'b0;
                end else begin
                    w_en_clr = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Register update; bus writes win over FSM updates of the same field
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_ctrl     <= 4'd0;
            r_preset   <= 32'd0;
            r_count    <= 32'd0;
            r_irq_flag <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_count    <= w_count_nxt;
            r_irq_flag <= w_wr_ctrl ? 1'b0 : w_flag_nxt;
            r_ctrl     <= w_wr_ctrl ? w_ctrl_merged[3:0] : w_ctrl_fsm[3:0];
            if (w_wr_preset) begin
                r_preset <= w_preset_merged;
            end
        end
    end

    // Zero-latency read mux; anything outside the window reads as zero
    always_comb begin
        rdata = 32'd0;
        if (w_hit) begin
            case (w_off)
                OFF_CTRL:   rdata = {28'd0, r_ctrl};
                OFF_PRESET: rdata = r_preset;
                OFF_COUNT:  rdata = r_count;
                default:    rdata = 32'd0;
            endcase
        end
    end

    assign hit = w_hit;
    assign irq = r_ctrl[CTRL_IM] & r_irq_flag;

endmodule

// File: tb/tb_timer_device.sv
// Self-checking bench for timer_device: register-map vectors from a table,
// then cycle-accurate timer sequences checked through an expectation queue.
module tb_timer_device;

    localparam logic [31:0] B      = 32'h0000_7F00;
    localparam logic [31:0] A_CTRL = B + 32'h0;
    localparam logic [31:0] A_PRE  = B + 32'h4;
    localparam logic [31:0] A_CNT  = B + 32'h8;
    localparam logic [31:0] A_GAP  = B + 32'hC;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr;
    logic [3:0]  byteen;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        hit;
    logic        irq;

    int checks   = 0;
    int failures = 0;

    timer_device #(.BASE_ADDR(B)) dut (
        .clk    (clk),
        .reset  (reset),
        .addr   (addr),
        .byteen (byteen),
        .wdata  (wdata),
        .rdata  (rdata),
        .hit    (hit),
        .irq    (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] wa;
        logic [31:0] wd;
        logic [3:0]  be;
        logic [31:0] ra;
        logic [31:0] exp_rd;
        logic        exp_hit;
    } vec_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] rd;
        logic        irq;
        int          step;
    } exp_t;

    vec_t  vecs[12];
    exp_t  q[$];
    string seq_name;
    int    step_no;

    task automatic cmp(input string tag, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d] got=%h expected=%h", tag, idx, act, exp);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        addr   = a;
        wdata  = d;
        byteen = be;
        @(posedge clk);
        #1;
        byteen = 4'h0;
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Expectations for the state after the next clock edge
    task automatic push(input logic [31:0] a, input logic [31:0] rd, input logic ex_irq);
        exp_t e;
        e.a    = a;
        e.rd   = rd;
        e.irq  = ex_irq;
        e.step = step_no;
        step_no++;
        q.push_back(e);
    endtask

    task automatic run_queue();
        exp_t e;
        while (q.size() > 0) begin
            e = q.pop_front();
            addr = e.a;
            @(posedge clk);
            #1;
            cmp({seq_name, ".rdata"}, e.step, rdata, e.rd);
            cmp({seq_name, ".irq"}, e.step, {31'd0, irq}, {31'd0, e.irq});
        end
    endtask

    task automatic check_now(input string tag, input logic [31:0] a, input logic [31:0] rd, input logic ex_irq);
        addr = a;
        #1;
        cmp({tag, ".rdata"}, 0, rdata, rd);
        cmp({tag, ".irq"}, 0, {31'd0, irq}, {31'd0, ex_irq});
    endtask

    function automatic vec_t mk(input logic [31:0] wa, input logic [31:0] wd, input logic [3:0] be,
                                input logic [31:0] ra, input logic [31:0] rd, input logic h);
        vec_t v;
        v.wa = wa; v.wd = wd; v.be = be; v.ra = ra; v.exp_rd = rd; v.exp_hit = h;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = mk(A_CTRL, 32'h0, 4'h0, A_CTRL, 32'h0, 1'b1);
        vecs[1]  = mk(A_CTRL, 32'h0, 4'h0, A_PRE,  32'h0, 1'b1);
        vecs[2]  = mk(A_CTRL, 32'h0, 4'h0, A_CNT,  32'h0, 1'b1);
        vecs[3]  = mk(A_CTRL, 32'h0, 4'h0, A_GAP,  32'h0, 1'b0);
        vecs[4]  = mk(A_CTRL, 32'h0, 4'h0, B + 32'h10, 32'h0, 1'b0);
        vecs[5]  = mk(A_PRE,  32'h1122_3344, 4'hF, A_PRE, 32'h1122_3344, 1'b1);
        vecs[6]  = mk(A_PRE,  32'hAABB_CCDD, 4'b0101, A_PRE, 32'h11BB_33DD, 1'b1);
        vecs[7]  = mk(A_CNT,  32'hFFFF_FFFF, 4'hF, A_CNT, 32'h0, 1'b1);
        vecs[8]  = mk(A_CTRL, 32'hFFFF_FFF6, 4'b0001, A_CTRL, 32'h6, 1'b1);
        vecs[9]  = mk(A_CTRL, 32'hFFFF_FFF0, 4'b1110, A_CTRL, 32'h6, 1'b1);
        vecs[10] = mk(A_GAP,  32'h0000_0000, 4'hF, A_PRE, 32'h11BB_33DD, 1'b1);
        vecs[11] = mk(A_PRE,  32'h5500_0000, 4'b1000, A_PRE, 32'h55BB_33DD, 1'b1);

        step_no = 0;
        reset  = 1'b0;
        addr   = 32'h0;
        wdata  = 32'h0;
        byteen = 4'h0;
        cycles(2);
        reset = 1'b1;

        // Dirty the registers and start the timer, then reset with a write pending
        wr(A_PRE, 32'hDEAD_BEEF, 4'hF);
        wr(A_CTRL, 32'h9, 4'hF);
        cycles(3);
        reset  = 1'b0;
        addr   = A_PRE;
        wdata  = 32'h1234_5678;
        byteen = 4'hF;
        cycles(2);
        byteen = 4'h0;
        reset  = 1'b1;
        check_now("rst_irq", A_CNT, 32'h0, 1'b0);

        // Register map, decode and byte-lane vectors
        for (int i = 0; i < 12; i++) begin
            if (vecs[i].be != 4'h0) begin
                wr(vecs[i].wa, vecs[i].wd, vecs[i].be);
            end
            addr = vecs[i].ra;
            #1;
            cmp("vec.rdata", i, rdata, vecs[i].exp_rd);
            cmp("vec.hit", i, {31'd0, hit}, {31'd0, vecs[i].exp_hit});
        end
        wr(A_CTRL, 32'h0, 4'hF);

        // One-shot countdown from 5
        seq_name = "oneshot";
        wr(A_PRE, 32'd5, 4'hF);
        wr(A_CTRL, 32'h9, 4'hF);
        push(A_CNT, 32'd0, 1'b0);
        push(A_CNT, 32'd5, 1'b0);
        push(A_CNT, 32'd4, 1'b0);
        push(A_CNT, 32'd3, 1'b0);
        push(A_CNT, 32'd2, 1'b0);
        push(A_CNT, 32'd1, 1'b0);
        push(A_CNT, 32'd0, 1'b1);
        push(A_CNT, 32'd0, 1'b1);
        push(A_CNT, 32'd0, 1'b1);
        run_queue();
        check_now("oneshot_en_clr", A_CTRL, 32'h8, 1'b1);
        wr(A_CTRL, 32'h0, 4'b0100);
        check_now("ctrl_wr_clears", A_CTRL, 32'h8, 1'b0);

        // Auto-reload with PRESET=3: one-cycle pulses every 6 cycles
        seq_name = "reload";
        wr(A_PRE, 32'd3, 4'hF);
        wr(A_CTRL, 32'hB, 4'hF);
        for (int k = 1; k <= 26; k++) begin
            push(A_CTRL, 32'hB, (k >= 5) && (((k - 5) % 6) == 0));
        end
        run_queue();
        wr(A_CTRL, 32'h0, 4'hF);
        cycles(3);
        check_now("reload_stop", A_CTRL, 32'h0, 1'b0);

        // EN cleared by a write landing on the LOAD edge: LOAD still completes
        seq_name = "load_clr";
        wr(A_PRE, 32'd7, 4'hF);
        wr(A_CTRL, 32'h1, 4'hF);
        cycles(1);
        wr(A_CTRL, 32'h0, 4'hF);
        check_now("load_clr_cnt", A_CNT, 32'd7, 1'b0);
        push(A_CNT, 32'd7, 1'b0);
        push(A_CNT, 32'd7, 1'b0);
        run_queue();

        // Disable mid-count, restart, then reset mid-count
        seq_name = "midop";
        wr(A_PRE, 32'd10, 4'hF);
        wr(A_CTRL, 32'h1, 4'hF);
        cycles(1);
        push(A_CNT, 32'd10, 1'b0);
        push(A_CNT, 32'd9, 1'b0);
        push(A_CNT, 32'd8, 1'b0);
        push(A_CNT, 32'd7, 1'b0);
        run_queue();
        wr(A_CTRL, 32'h0, 4'hF);
        check_now("freeze", A_CNT, 32'd6, 1'b0);
        push(A_CNT, 32'd6, 1'b0);
        push(A_CNT, 32'd6, 1'b0);
        push(A_CNT, 32'd6, 1'b0);
        run_queue();
        wr(A_CTRL, 32'h1, 4'hF);
        push(A_CNT, 32'd6, 1'b0);
        push(A_CNT, 32'd10, 1'b0);
        push(A_CNT, 32'd9, 1'b0);
        push(A_CNT, 32'd8, 1'b0);
        run_queue();
        reset = 1'b0;
        push(A_CNT, 32'd0, 1'b0);
        run_queue();
        check_now("rst_ctrl", A_CTRL, 32'h0, 1'b0);
        check_now("rst_pre", A_PRE, 32'h0, 1'b0);
        reset = 1'b1;
        push(A_CNT, 32'd0, 1'b0);
        push(A_CNT, 32'd0, 1'b0);
        run_queue();

        // PRESET=0: expiry right after LOAD; masked by IM=0, then visible with IM=1
        seq_name = "zero_masked";
        wr(A_CTRL, 32'h1, 4'hF);
        for (int k = 0; k < 5; k++) begin
            push(A_CNT, 32'd0, 1'b0);
        end
        run_queue();
        check_now("zero_en_clr", A_CTRL, 32'h0, 1'b0);
        seq_name = "zero_im";
        wr(A_CTRL, 32'h9, 4'hF);
        push(A_CNT, 32'd0, 1'b0);
        push(A_CNT, 32'd0, 1'b0);
        push(A_CNT, 32'd0, 1'b1);
        push(A_CNT, 32'd0, 1'b1);
        push(A_CNT, 32'd0, 1'b1);
        run_queue();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
